// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcode/funct3 constants, ALU and immediate-format enums, decode helpers
package rv32i_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_t fmt);
    return fmt == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           fmt == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           fmt == IMM_U ? {i[31:12], 12'b0} :
           fmt == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
                          {{20{i[31]}}, i[31:20]};
  endfunction
  function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
    return f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
           f3 == 3'b001 ? ALU_SLL :
           f3 == 3'b010 ? ALU_SLT :
           f3 == 3'b011 ? ALU_SLTU :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'b110 ? ALU_OR : ALU_AND;
  endfunction
endpackage

// File: rtl/rv32i_regfile.sv
// rv32i_regfile: 32x32 register file, two async reads, one sync write, x0 reads zero
module rv32i_regfile (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        we,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] rf [0:31];
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset)
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (we && rd_addr != 5'd0)
      rf[rd_addr] <= rd_data;
  assign rs1_data = rs1_addr == 5'd0 ? '0 : rf[rs1_addr];
  assign rs2_data = rs2_addr == 5'd0 ? '0 : rf[rs2_addr];
endmodule

// File: rtl/rv32i_cpu_core.sv
// rv32i_cpu_core: single-cycle RV32I core, async instruction fetch, combinational-load data bus
module rv32i_cpu_core
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [31:0]     INSTRUCTION,
  input  logic [XLEN-1:0] MEM_data,
  output logic [31:0]     Instr_Addr,
  output logic [XLEN-1:0] MEM_addr,
  output logic [XLEN-1:0] MEM_WR_out,
  output logic [2:0]      MEM_type,
  output logic            MEM_rd_en,
  output logic            MEM_wr_en
);
  logic [1:0]  rst_sync;
  logic        run;
  logic [31:0] pc, pc_plus4, imm, rs1_v, rs2_v, a, b, alu_y, wb;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  alu_op_t     alu_op;
  imm_fmt_t    imm_fmt;
  logic        use_imm, a_pc, reg_wr, rd_en, wr_en, jal, jalr, branch, cond, taken;
  // Core stays idle until the deasserted reset has passed two flops
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign run = rst_sync[1];
  assign opcode = INSTRUCTION[6:0];
  assign rd = INSTRUCTION[11:7];
  assign f3 = INSTRUCTION[14:12];
  assign rs1 = INSTRUCTION[19:15];
  assign rs2 = INSTRUCTION[24:20];
  always_comb begin
    alu_op = ALU_ADD;
    imm_fmt = IMM_I;
    use_imm = 1'b0;
    a_pc = 1'b0;
    reg_wr = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    jal = 1'b0;
    jalr = 1'b0;
    branch = 1'b0;
    case (opcode)
      OP_LUI: begin reg_wr = 1'b1; use_imm = 1'b1; imm_fmt = IMM_U; alu_op = ALU_PASSB; end
      OP_AUIPC: begin reg_wr = 1'b1; use_imm = 1'b1; imm_fmt = IMM_U; a_pc = 1'b1; end
      OP_JAL: begin reg_wr = 1'b1; jal = 1'b1; imm_fmt = IMM_J; end
      OP_JALR: begin reg_wr = 1'b1; jalr = 1'b1; use_imm = 1'b1; end
      OP_BRANCH: begin branch = 1'b1; imm_fmt = IMM_B; end
      OP_LOAD: begin reg_wr = 1'b1; rd_en = 1'b1; use_imm = 1'b1; end
      OP_STORE: begin wr_en = 1'b1; use_imm = 1'b1; imm_fmt = IMM_S; end
      OP_OPIMM: begin reg_wr = 1'b1; use_imm = 1'b1; alu_op = alu_dec(f3, f3 == 3'b101 && INSTRUCTION[30]); end
      OP_OP: begin reg_wr = 1'b1; alu_op = alu_dec(f3, INSTRUCTION[30]); end
      default: ;
    endcase
  end
  assign imm = imm_gen(INSTRUCTION, imm_fmt);
  rv32i_regfile u_rf (
    .CLK(CLK), .Reset(Reset), .we(run && reg_wr),
    .rs1_addr(rs1), .rs2_addr(rs2), .rd_addr(rd), .rd_data(wb),
    .rs1_data(rs1_v), .rs2_data(rs2_v)
  );
  assign a = a_pc ? pc : rs1_v;
  assign b = use_imm ? imm : rs2_v;
  always_comb begin
    case (alu_op)
      ALU_SUB:   alu_y = a - b;
      ALU_SLL:   alu_y = a << b[4:0];
      ALU_SLT:   alu_y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  alu_y = {31'b0, a < b};
      ALU_XOR:   alu_y = a ^ b;
      ALU_SRL:   alu_y = a >> b[4:0];
      ALU_SRA:   alu_y = $signed(a) >>> b[4:0];
      ALU_OR:    alu_y = a | b;
      ALU_AND:   alu_y = a & b;
      ALU_PASSB: alu_y = b;
      default:   alu_y = a + b;
    endcase
  end
  assign cond = f3 == 3'b000 ? rs1_v == rs2_v :
                f3 == 3'b001 ? rs1_v != rs2_v :
                f3 == 3'b100 ? $signed(rs1_v) < $signed(rs2_v) :
                f3 == 3'b101 ? $signed(rs1_v) >= $signed(rs2_v) :
                f3 == 3'b110 ? rs1_v < rs2_v :
                f3 == 3'b111 ? rs1_v >= rs2_v : 1'b0;
  assign taken = branch && cond;
  assign pc_plus4 = pc + 32'd4;
  assign wb = (jal || jalr) ? pc_plus4 : rd_en ? MEM_data : alu_y;
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) pc <= RESET_PC;
    else if (run) pc <= jalr ? {alu_y[31:1], 1'b0} : (jal || taken) ? pc + imm : pc_plus4;
  assign Instr_Addr = pc;
  assign MEM_rd_en = run && rd_en;
  assign MEM_wr_en = run && wr_en;
  assign MEM_addr = run ? alu_y : '0;
  assign MEM_WR_out = run ? rs2_v : '0;
  assign MEM_type = run ? f3 : F3_W;
endmodule

// File: tb/tb_rv32i_cpu_core.sv
// tb_rv32i_cpu_core: directed tests for the single-cycle RV32I core
module tb_rv32i_cpu_core;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] INSTRUCTION, MEM_data, Instr_Addr, MEM_addr, MEM_WR_out;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en, MEM_wr_en;
  logic [31:0] imem [0:63];
  int checks = 0;
  int errors = 0;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, OPIMM = 7'h13;
  rv32i_cpu_core dut (
    .CLK(CLK), .Reset(Reset), .INSTRUCTION(INSTRUCTION), .MEM_data(MEM_data),
    .Instr_Addr(Instr_Addr), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
    .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en)
  );
  always #5 CLK = ~CLK;
  assign INSTRUCTION = imem[Instr_Addr[7:2]];
  function automatic logic [31:0] i_t(input logic [31:0] imm, rs1, f3, rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] r_t(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] s_t(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(input logic [31:0] imm, rd, input logic [6:0] op);
    return {imm[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] j_t(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask
  task automatic reset_core();
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    clear_imem();
    Reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (Instr_Addr !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", Instr_Addr); end
    checks++; if ({MEM_rd_en, MEM_wr_en} !== 2'b00) begin errors++; $display("FAIL rst_en got %b exp 00", {MEM_rd_en, MEM_wr_en}); end
    checks++; if (MEM_type !== 3'b010) begin errors++; $display("FAIL rst_type got %b exp 010", MEM_type); end
    checks++; if ({MEM_addr, MEM_WR_out} !== 64'h0) begin errors++; $display("FAIL rst_bus got %h/%h exp 0/0", MEM_addr, MEM_WR_out); end
    @(negedge CLK) Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (Instr_Addr !== 32'h0) begin errors++; $display("FAIL first_fetch got %h exp 0", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h4) begin errors++; $display("FAIL fetch2 got %h exp 4", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h8) begin errors++; $display("FAIL fetch3 got %h exp 8", Instr_Addr); end
  endtask
  task automatic test_alu();
    clear_imem();
    imem[0] = i_t(5, 0, 0, 1, OPIMM);
    imem[1] = i_t(-3, 0, 0, 2, OPIMM);
    imem[2] = r_t(0, 2, 1, 0, 3);
    imem[3] = r_t(32, 1, 2, 0, 4);
    imem[4] = r_t(0, 1, 2, 2, 5);
    imem[5] = r_t(0, 1, 2, 3, 6);
    imem[6] = i_t(7, 0, 0, 0, OPIMM);
    imem[7] = i_t(32'h401, 4, 5, 10, OPIMM);
    imem[8] = i_t(28, 4, 5, 11, OPIMM);
    imem[9] = r_t(0, 1, 1, 1, 12);
    imem[10] = s_t(0, 0, 0, 2);
    reset_core();
    step(10);
    checks++; if (dut.u_rf.rf[3] !== 32'h2) begin errors++; $display("FAIL add got %h exp 2", dut.u_rf.rf[3]); end
    checks++; if (dut.u_rf.rf[4] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL sub got %h exp fffffff8", dut.u_rf.rf[4]); end
    checks++; if (dut.u_rf.rf[5] !== 32'h1) begin errors++; $display("FAIL slt got %h exp 1", dut.u_rf.rf[5]); end
    checks++; if (dut.u_rf.rf[6] !== 32'h0) begin errors++; $display("FAIL sltu got %h exp 0", dut.u_rf.rf[6]); end
    checks++; if (dut.u_rf.rf[10] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL srai got %h exp fffffffc", dut.u_rf.rf[10]); end
    checks++; if (dut.u_rf.rf[11] !== 32'hF) begin errors++; $display("FAIL srli got %h exp f", dut.u_rf.rf[11]); end
    checks++; if (dut.u_rf.rf[12] !== 32'hA0) begin errors++; $display("FAIL sll got %h exp a0", dut.u_rf.rf[12]); end
    checks++; if (MEM_wr_en !== 1'b1 || MEM_WR_out !== 32'h0) begin errors++; $display("FAIL x0_read got wr_en=%b data=%h exp 1/0", MEM_wr_en, MEM_WR_out); end
  endtask
  task automatic test_mem();
    clear_imem();
    imem[0] = i_t(5, 0, 0, 1, OPIMM);
    imem[1] = i_t(-3, 0, 0, 2, OPIMM);
    imem[2] = r_t(0, 2, 1, 0, 3);
    imem[3] = s_t(8, 3, 0, 2);
    imem[4] = i_t(8, 0, 0, 7, 7'h03);
    imem[5] = i_t(8, 0, 4, 8, 7'h03);
    MEM_data = 32'hFFFF_FF80;
    reset_core();
    step(3);
    checks++; if ({MEM_wr_en, MEM_rd_en} !== 2'b10) begin errors++; $display("FAIL sw_en got wr/rd=%b exp 10", {MEM_wr_en, MEM_rd_en}); end
    checks++; if (MEM_addr !== 32'h8 || MEM_WR_out !== 32'h2 || MEM_type !== 3'b010) begin errors++; $display("FAIL sw_bus got %h/%h/%b exp 8/2/010", MEM_addr, MEM_WR_out, MEM_type); end
    step(1);
    checks++; if ({MEM_wr_en, MEM_rd_en} !== 2'b01 || MEM_type !== 3'b000 || MEM_addr !== 32'h8) begin errors++; $display("FAIL lb_bus got %b/%b/%h exp 01/000/8", {MEM_wr_en, MEM_rd_en}, MEM_type, MEM_addr); end
    step(1);
    checks++; if (dut.u_rf.rf[7] !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", dut.u_rf.rf[7]); end
    checks++; if (MEM_rd_en !== 1'b1 || MEM_type !== 3'b100) begin errors++; $display("FAIL lbu_bus got %b/%b exp 1/100", MEM_rd_en, MEM_type); end
    MEM_data = 32'h0000_0080;
    step(1);
    checks++; if (dut.u_rf.rf[8] !== 32'h80) begin errors++; $display("FAIL lbu_data got %h exp 80", dut.u_rf.rf[8]); end
    checks++; if ({MEM_wr_en, MEM_rd_en} !== 2'b00) begin errors++; $display("FAIL nonmem_en got %b exp 00", {MEM_wr_en, MEM_rd_en}); end
  endtask
  task automatic test_branch();
    clear_imem();
    imem[0] = i_t(5, 0, 0, 1, OPIMM);
    imem[1] = i_t(-1, 0, 0, 2, OPIMM);
    imem[8] = b_t(12, 1, 1, 0);
    imem[11] = b_t(12, 1, 1, 1);
    imem[12] = b_t(8, 1, 2, 4);
    imem[14] = b_t(8, 1, 2, 6);
    imem[15] = b_t(8, 2, 1, 5);
    imem[17] = b_t(8, 2, 1, 7);
    reset_core();
    step(8);
    checks++; if (Instr_Addr !== 32'h20) begin errors++; $display("FAIL br_start got %h exp 20", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h2C) begin errors++; $display("FAIL beq got %h exp 2c", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h30) begin errors++; $display("FAIL bne got %h exp 30", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h38) begin errors++; $display("FAIL blt got %h exp 38", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h3C) begin errors++; $display("FAIL bltu got %h exp 3c", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h44) begin errors++; $display("FAIL bge got %h exp 44", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h48) begin errors++; $display("FAIL bgeu got %h exp 48", Instr_Addr); end
  endtask
  task automatic test_jump();
    clear_imem();
    imem[16] = j_t(16, 1);
    imem[20] = i_t(1, 1, 0, 0, JALR);
    imem[17] = u_t(32'h12345, 8, LUI);
    imem[18] = j_t(32'h18, 0);
    imem[24] = u_t(1, 9, AUIPC);
    imem[25] = i_t(32'h71, 0, 0, 10, JALR);
    reset_core();
    step(17);
    checks++; if (Instr_Addr !== 32'h50 || dut.u_rf.rf[1] !== 32'h44) begin errors++; $display("FAIL jal got pc=%h x1=%h exp 50/44", Instr_Addr, dut.u_rf.rf[1]); end
    step(1);
    checks++; if (Instr_Addr !== 32'h44) begin errors++; $display("FAIL jalr got %h exp 44", Instr_Addr); end
    step(1);
    checks++; if (dut.u_rf.rf[8] !== 32'h1234_5000) begin errors++; $display("FAIL lui got %h exp 12345000", dut.u_rf.rf[8]); end
    step(1);
    checks++; if (Instr_Addr !== 32'h60) begin errors++; $display("FAIL jal_x0 got %h exp 60", Instr_Addr); end
    step(1);
    checks++; if (dut.u_rf.rf[9] !== 32'h1060) begin errors++; $display("FAIL auipc got %h exp 1060", dut.u_rf.rf[9]); end
    step(1);
    checks++; if (Instr_Addr !== 32'h70 || dut.u_rf.rf[10] !== 32'h68) begin errors++; $display("FAIL jalr_link got pc=%h x10=%h exp 70/68", Instr_Addr, dut.u_rf.rf[10]); end
  endtask
  task automatic test_nop_wrap_reset();
    clear_imem();
    imem[0] = i_t(5, 0, 0, 1, OPIMM);
    imem[1] = i_t(7, 0, 0, 2, OPIMM);
    imem[2] = 32'hFFFF_FFFF;
    imem[3] = i_t(-4, 0, 0, 0, JALR);
    reset_core();
    step(2);
    checks++; if ({MEM_wr_en, MEM_rd_en} !== 2'b00) begin errors++; $display("FAIL undef_en got %b exp 00", {MEM_wr_en, MEM_rd_en}); end
    step(1);
    checks++; if (Instr_Addr !== 32'hC || dut.u_rf.rf[31] !== 32'h0) begin errors++; $display("FAIL undef_nop got pc=%h x31=%h exp c/0", Instr_Addr, dut.u_rf.rf[31]); end
    step(1);
    checks++; if (Instr_Addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jalr_top got %h exp fffffffc", Instr_Addr); end
    step(1);
    checks++; if (Instr_Addr !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", Instr_Addr); end
    step(2);
    checks++; if (Instr_Addr !== 32'h8 || dut.u_rf.rf[1] !== 32'h5 || dut.u_rf.rf[2] !== 32'h7) begin errors++; $display("FAIL pre_rst got pc=%h x1=%h x2=%h exp 8/5/7", Instr_Addr, dut.u_rf.rf[1], dut.u_rf.rf[2]); end
    step(1);
    #2 Reset = 1'b0;
    #1;
    checks++; if (Instr_Addr !== 32'h0 || dut.u_rf.rf[1] !== 32'h0 || dut.u_rf.rf[2] !== 32'h0) begin errors++; $display("FAIL mid_rst got pc=%h x1=%h x2=%h exp 0/0/0", Instr_Addr, dut.u_rf.rf[1], dut.u_rf.rf[2]); end
    step(1);
    checks++; if (Instr_Addr !== 32'h0 || dut.u_rf.rf[1] !== 32'h0 || MEM_wr_en !== 1'b0) begin errors++; $display("FAIL rst_hold got pc=%h x1=%h wr=%b exp 0/0/0", Instr_Addr, dut.u_rf.rf[1], MEM_wr_en); end
  endtask
  initial begin
    MEM_data = 32'h0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump();
    test_nop_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
